signed_accumulator: RTL
=======================

SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 Parameter A_W, default 4: width of operand a.
REQ-002 Parameter B_W, default 3: width of operand b, always signed.
REQ-003 Parameter ACC_W, default 8: signed accumulator and result width; SHALL be at least max(A_W,B_W)+2.
REQ-004 Parameter N_BEATS, default 8: accepted beats per result; SHALL be at least 1.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 clear  in  1  synchronous flush of the accumulation in progress.
REQ-008 in_valid  in  1  operand beat valid.
REQ-009 in_ready  out  1  block accepts a beat.
REQ-010 a  in  A_W  operand a.
REQ-011 a_signed  in  1  1: a is two's complement; 0: a is unsigned; sampled per beat.
REQ-012 b  in  B_W  signed operand b.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 acc_out  out  ACC_W  signed result.
REQ-016 sat  out  1  sticky flag: saturation occurred during this result.
REQ-017 beat_cnt  out  $clog2(N_BEATS+1)  beats accepted toward the current result.

Function
REQ-018 The block SHALL have two states: ACC (accepting beats) and HOLD (result pending); in_ready SHALL be 1 in ACC and 0 in HOLD.
REQ-019 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-020 Per beat, term = ext(a) + sext(b), computed at ACC_W+1 bits; ext(a) SHALL be sign-extended when a_signed=1 and zero-extended when a_signed=0.
REQ-021 On an accepted beat: acc <= acc + term, and beat_cnt SHALL increment.
REQ-022 On the beat that makes beat_cnt equal N_BEATS, the block SHALL enter HOLD, and out_valid SHALL be 1 the following cycle (latency 1 cycle from the last accepted beat).
REQ-023 In HOLD, acc_out and sat SHALL be held stable until out_ready=1.
REQ-024 A HOLD cycle with out_ready=1 SHALL complete the handshake and return to ACC with acc=0, beat_cnt=0, sat=0, out_valid=0. No beat SHALL be accepted in that same cycle.
REQ-025 In ACC, acc_out SHALL show the running sum and out_valid SHALL be 0.
REQ-026 clear=1 SHALL zero acc, beat_cnt and sat, and force ACC and out_valid=0 in any state; it SHALL take priority over both the input beat and the output handshake in the same cycle.
REQ-027 in_valid=0 cycles SHALL leave all state unchanged (no bubble penalty).

Reset
REQ-028 With rst_n=0, all of the following SHALL hold asynchronously, independent of clk: state=ACC, acc_out=0, beat_cnt=0, sat=0, out_valid=0, in_ready=1.
REQ-029 Reset asserted mid-accumulation or in HOLD SHALL discard the partial or pending result; the first beat after release SHALL start a new result.
REQ-030 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Configuration
REQ-031 Macro SIGNED_ACCUMULATOR_SAT_EN: when defined, each accumulate SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat whenever a clamp occurs.
REQ-032 When SIGNED_ACCUMULATOR_SAT_EN is undefined, the accumulate SHALL wrap modulo 2^ACC_W, and sat SHALL be constant 0.

Verification (default parameters)
REQ-033 8 beats of a=4'd13, a_signed=1, b=3'sd2, out_ready=1 -> term -1 per beat; out_valid 1 cycle after beat 8; acc_out=-8; sat=0.
REQ-034 8 beats of a=4'd13, a_signed=0, b=3'sd2 -> term 15 per beat; acc_out=120; sat=0; in_ready=0 while out_valid=1.
REQ-035 8 beats of a=4'd15, a_signed=0, b=3'sd3 -> with SAT_EN: acc_out=127, sat=1; without SAT_EN: acc_out=-112, sat=0.
REQ-036 Hold out_ready=0 for 5 cycles after the result with in_valid=1 -> acc_out stable, no beat accepted; out_ready=1 -> next cycle out_valid=0, beat_cnt=0, in_ready=1.
REQ-037 Send 3 beats, then clear=1 together with in_valid=1 -> acc_out=0, beat_cnt=0; repeat with rst_n pulsed low between clock edges -> outputs zero immediately.

Source files
------------

// File: rtl/signed_accumulator.sv
// Signed multiply-free accumulator: sums N_BEATS terms ext(a)+sext(b) into one ACC_W-bit result.
// Latency: result valid 1 cycle after the last accepted beat; in_ready drops while the result is held.
// Backpressure: result is held until out_ready; SIGNED_ACCUMULATOR_SAT_EN selects clamping instead of wrap.
module signed_accumulator #(
    parameter int A_W     = 4,
    parameter int B_W     = 3,
    parameter int ACC_W   = 8,
    parameter int N_BEATS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [A_W-1:0]                   a,
    input  logic                             a_signed,
    input  logic [B_W-1:0]                   b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 acc_out,
    output logic                             sat,
    output logic [$clog2(N_BEATS+1)-1:0]     beat_cnt
);

    localparam int CNT_W = $clog2(N_BEATS + 1);
    localparam int T_W   = ACC_W + 1;
    localparam int S_W   = ACC_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [ACC_W-1:0]       acc;
    logic [CNT_W-1:0]       cnt;
    logic signed [T_W-1:0]  ext_a;
    logic signed [T_W-1:0]  ext_b;
    logic signed [T_W-1:0]  term;
    logic signed [S_W-1:0]  sum;
    logic [ACC_W-1:0]       acc_next;
    logic                   accept;

    assign acc_out  = acc;
    assign beat_cnt = cnt;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ext_a = a_signed ? {{(T_W-A_W){a[A_W-1]}}, a} : {{(T_W-A_W){1'b0}}, a};
        ext_b = {{(T_W-B_W){b[B_W-1]}}, b};
        term  = ext_a + ext_b;
        sum   = {{2{acc[ACC_W-1]}}, acc} + {term[T_W-1], term};
    end

`ifdef SIGNED_ACCUMULATOR_SAT_EN
    localparam logic signed [S_W-1:0] SUM_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] SUM_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    logic clamp;
    logic sat_q;

    always_comb begin
        clamp    = 1'b0;
        acc_next = sum[ACC_W-1:0];
        if (sum > SUM_MAX) begin
            acc_next = SUM_MAX[ACC_W-1:0];
            clamp    = 1'b1;
        end else if (sum < SUM_MIN) begin
            acc_next = SUM_MIN[ACC_W-1:0];
            clamp    = 1'b1;
        end
    end

    // Sticky for the result in progress; dropped whenever a new result starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clear) begin
            sat_q <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (out_ready) begin
                sat_q <= 1'b0;
            end
        end else if (accept && clamp) begin
            sat_q <= 1'b1;
        end
    end

    assign sat = sat_q;
`else
    assign acc_next = ACC_W'(sum);
    assign sat      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (clear) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Handshake cycle only retires the result; beats resume next cycle.
                    if (out_ready) begin
                        state     <= ST_ACC;
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
